// File: rtl/regfile_arbiter_if.sv
// Bundle of the requester, response and register-file signals around regfile_arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold valid and fields until the matching one-cycle ready pulse.
// Ports: slave = arbiter side (takes requests and file read data, drives everything else);
//        master = environment side (requesters plus register file), the mirror image.
interface regfile_arbiter_if #(
  parameter int n = 4,
  parameter int m = 8
);
  logic         req0_valid;
  logic         req0_wr;
  logic [n-1:0] req0_addr;
  logic [m-1:0] req0_wdata;
  logic         req0_ready;
  logic         req1_valid;
  logic         req1_wr;
  logic [n-1:0] req1_addr;
  logic [m-1:0] req1_wdata;
  logic         req1_ready;

  logic         rsp0_valid;
  logic [m-1:0] rsp0_data;
  logic         rsp0_err;
  logic         rsp1_valid;
  logic [m-1:0] rsp1_data;
  logic         rsp1_err;

  logic         RdEn;
  logic         WrEn;
  logic [n-1:0] address;
  logic [m-1:0] WrData;
  logic [m-1:0] RdData;
  logic         Rd_dataValid;

  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_err,
    output rsp1_valid, rsp1_data, rsp1_err,
    output RdEn, WrEn, address, WrData,
    input  RdData, Rd_dataValid
  );

  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err,
    input  rsp1_valid, rsp1_data, rsp1_err,
    input  RdEn, WrEn, address, WrData,
    output RdData, Rd_dataValid
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file; reads bounded by a timeout.
// Latency: strobe+ready 1 cycle after grant; read rsp 3 cycles (1-cycle file) or TIMEOUT+1 after RdEn.
// Backpressure: valid sampled only in IDLE; one access in flight; ready pulses once per accepted request.
// Ports: Clk, Rst (synchronous, active-high); bus = slave side of regfile_arbiter_if
//        (req0/req1 request+ready, rsp0/rsp1 valid/data/err, RdEn/WrEn/address/WrData/RdData/Rd_dataValid);
//        arb_busy = high while an access is in WR, RD or WAIT.
module regfile_arbiter #(
  parameter int n       = 4,
  parameter int m       = 8,
  parameter int TIMEOUT = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  regfile_arbiter_if.slave bus,
  output logic             arb_busy
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req0_ready_q, req0_ready_d;
  logic          req1_ready_q, req1_ready_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [m-1:0]  rsp0_data_q, rsp0_data_d;
  logic [m-1:0]  rsp1_data_q, rsp1_data_d;
  logic          rsp0_err_q, rsp0_err_d;
  logic          rsp1_err_q, rsp1_err_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic [n-1:0]  address_q, address_d;
  logic [m-1:0]  wr_data_q, wr_data_d;
  logic          busy_q, busy_d;

  logic          gnt_any;
  logic          gnt;
  logic          sel_wr;
  logic          timed_out;
  logic [m-1:0]  rsp_dat;

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_err_d   = rsp1_err_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    address_d    = address_q;
    wr_data_d    = wr_data_q;

    // Round robin: on a tie the requester that did not win last time goes;
    // a lone requester wins regardless of the pointer.
    gnt_any   = bus.req0_valid | bus.req1_valid;
    gnt       = (bus.req0_valid & bus.req1_valid) ? ~last_gnt_q : bus.req1_valid;
    sel_wr    = gnt ? bus.req1_wr : bus.req0_wr;
    timed_out = (cnt_q == CW'(TIMEOUT - 1));
    rsp_dat   = bus.Rd_dataValid ? bus.RdData : '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          owner_d      = gnt;
          last_gnt_d   = gnt;
          req0_ready_d = ~gnt;
          req1_ready_d = gnt;
          address_d    = gnt ? bus.req1_addr : bus.req0_addr;
          if (sel_wr) begin
            state_d   = ST_WR;
            wr_en_d   = 1'b1;
            wr_data_d = gnt ? bus.req1_wdata : bus.req0_wdata;
          end else begin
            state_d = ST_RD;
            rd_en_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      ST_RD: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // Data arriving on the last allowed cycle still counts as a good read.
        if (bus.Rd_dataValid || timed_out) begin
          state_d = ST_IDLE;
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = rsp_dat;
            rsp1_err_d   = ~bus.Rd_dataValid;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = rsp_dat;
            rsp0_err_d   = ~bus.Rd_dataValid;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      last_gnt_q   <= 1'b1;  // requester 0 wins the first tie
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      address_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      req0_ready_q <= req0_ready_d;
      req1_ready_q <= req1_ready_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      address_q    <= address_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req0_ready = req0_ready_q;
  assign bus.req1_ready = req1_ready_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign bus.rsp0_err   = rsp0_err_q;
  assign bus.rsp1_err   = rsp1_err_q;
  assign bus.RdEn       = rd_en_q;
  assign bus.WrEn       = wr_en_q;
  assign bus.address    = address_q;
  assign bus.WrData     = wr_data_q;
  assign arb_busy       = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed requests, a 1-cycle register-file model and a
// scoreboard of expected output events (cycle, strobes, readies, responses, held fields).
module tb_regfile_arbiter;

  typedef struct packed {
    int         cyc;
    logic       we, re, k0, k1, v0, v1, busy;
    logic [3:0] addr;
    logic [7:0] wd, d0, d1;
    logic       e0, e1;
  } ev_t;

  logic clk;
  logic rst;
  logic arb_busy;
  int   cyc = 0;

  logic       r0_vld, r0_wr, r1_vld, r1_wr;
  logic [3:0] r0_addr, r1_addr;
  logic [7:0] r0_wd, r1_wd;
  logic       rf_vld, spur_vld, rf_mute, rf_pend;
  logic [7:0] rf_data, spur_data, rf_pdata;
  logic       chk_reset, done;
  logic [7:0] mem [16];

  logic [3:0] exp_addr;
  logic [7:0] exp_wd, exp_d0, exp_d1;
  logic       exp_e0, exp_e1;
  ev_t        sb [$];

  int n_cmp = 0;
  int n_bad = 0;

  regfile_arbiter_if #(.n(4), .m(8)) bus ();

  regfile_arbiter #(.n(4), .m(8), .TIMEOUT(8)) dut (
    .Clk      (clk),
    .Rst      (rst),
    .bus      (bus),
    .arb_busy (arb_busy)
  );

  assign bus.req0_valid   = r0_vld;
  assign bus.req0_wr      = r0_wr;
  assign bus.req0_addr    = r0_addr;
  assign bus.req0_wdata   = r0_wd;
  assign bus.req1_valid   = r1_vld;
  assign bus.req1_wr      = r1_wr;
  assign bus.req1_addr    = r1_addr;
  assign bus.req1_wdata   = r1_wd;
  assign bus.Rd_dataValid = rf_vld | spur_vld;
  assign bus.RdData       = rf_vld ? rf_data : spur_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Register file with one cycle of read latency; can be muted to force a timeout.
  always @(negedge clk) begin
    if (bus.WrEn) mem[bus.address] = bus.WrData;
    rf_pend  = bus.RdEn && !rf_mute;
    rf_pdata = mem[bus.address];
  end

  always @(posedge clk) begin
    #1;
    rf_vld  = rf_pend;
    rf_data = rf_pdata;
  end

  function automatic string fmt(input ev_t x);
    return $sformatf("cyc=%0d we=%b re=%b rdy=%b%b rv=%b%b busy=%b addr=%h wd=%h d0=%h e0=%b d1=%h e1=%b",
                     x.cyc, x.we, x.re, x.k0, x.k1, x.v0, x.v1, x.busy, x.addr, x.wd, x.d0, x.e0, x.d1, x.e1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expected event for every cycle the DUT shows activity.
  always @(negedge clk) begin
    ev_t o;
    ev_t e;
    if (chk_reset) begin
      chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
      chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      chk("rst_rsp0_data",  32'(bus.rsp0_data),  32'd0);
      chk("rst_rsp1_data",  32'(bus.rsp1_data),  32'd0);
      chk("rst_rsp0_err",   32'(bus.rsp0_err),   32'd0);
      chk("rst_rsp1_err",   32'(bus.rsp1_err),   32'd0);
      chk("rst_RdEn",       32'(bus.RdEn),       32'd0);
      chk("rst_WrEn",       32'(bus.WrEn),       32'd0);
      chk("rst_address",    32'(bus.address),    32'd0);
      chk("rst_WrData",     32'(bus.WrData),     32'd0);
      chk("rst_arb_busy",   32'(arb_busy),       32'd0);
    end else if (!rst && (bus.WrEn || bus.RdEn || bus.req0_ready || bus.req1_ready ||
                          bus.rsp0_valid || bus.rsp1_valid)) begin
      o.cyc  = cyc;
      o.we   = bus.WrEn;
      o.re   = bus.RdEn;
      o.k0   = bus.req0_ready;
      o.k1   = bus.req1_ready;
      o.v0   = bus.rsp0_valid;
      o.v1   = bus.rsp1_valid;
      o.busy = arb_busy;
      o.addr = bus.address;
      o.wd   = bus.WrData;
      o.d0   = bus.rsp0_data;
      o.e0   = bus.rsp0_err;
      o.d1   = bus.rsp1_data;
      o.e1   = bus.rsp1_err;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL event_unexpected: got %s expected none", fmt(o));
      end else begin
        e = sb.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL event: got %s expected %s", fmt(o), fmt(e));
        end
      end
    end
    if (done || cyc > 4000) begin
      if (cyc > 4000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got cyc=%0d expected under 4000", cyc);
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic tick(input int nc);
    for (int i = 0; i < nc; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit r, input logic v, input logic w, input logic [3:0] a, input logic [7:0] d);
    if (r) begin
      r1_vld = v; r1_wr = w; r1_addr = a; r1_wd = d;
    end else begin
      r0_vld = v; r0_wr = w; r0_addr = a; r0_wd = d;
    end
  endtask

  task automatic ev(input int c, input logic we, input logic re, input logic k0, input logic k1,
                    input logic v0, input logic v1);
    ev_t e;
    e.cyc = c; e.we = we; e.re = re; e.k0 = k0; e.k1 = k1; e.v0 = v0; e.v1 = v1;
    e.busy = we | re;
    e.addr = exp_addr; e.wd = exp_wd;
    e.d0 = exp_d0; e.e0 = exp_e0; e.d1 = exp_d1; e.e1 = exp_e1;
    sb.push_back(e);
  endtask

  // Issued in an IDLE cycle k: strobe+ready at k+1, IDLE again at k+2.
  task automatic wr_op(input bit r, input logic [3:0] a, input logic [7:0] d);
    int k;
    k = cyc;
    exp_addr = a;
    exp_wd   = d;
    ev(k + 1, 1'b1, 1'b0, !r, r, 1'b0, 1'b0);
    drive(r, 1'b1, 1'b1, a, d);
    tick(2);
    drive(r, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  // Read issued in IDLE cycle k: RdEn+ready at k+1, rsp at k+3, or at k+10 on timeout.
  task automatic rd_op(input bit r, input logic [3:0] a, input logic [7:0] d, input bit to);
    int k;
    int rc;
    k  = cyc;
    rc = to ? k + 10 : k + 3;
    exp_addr = a;
    ev(k + 1, 1'b0, 1'b1, !r, r, 1'b0, 1'b0);
    if (r) begin
      exp_d1 = to ? 8'h00 : d;
      exp_e1 = to;
    end else begin
      exp_d0 = to ? 8'h00 : d;
      exp_e0 = to;
    end
    ev(rc, 1'b0, 1'b0, 1'b0, 1'b0, !r, r);
    rf_mute = to;
    drive(r, 1'b1, 1'b0, a, 8'h00);
    tick(2);
    drive(r, 1'b0, 1'b0, 4'h0, 8'h00);
    tick(rc - k - 2);
    rf_mute = 1'b0;
  endtask

  initial begin
    logic [3:0] alt_a [2][4];
    logic [7:0] alt_d [2][4];
    int k;
    alt_a[0][0] = 4'h1; alt_a[0][1] = 4'h3; alt_a[0][2] = 4'h5; alt_a[0][3] = 4'h7;
    alt_d[0][0] = 8'h11; alt_d[0][1] = 8'h33; alt_d[0][2] = 8'h55; alt_d[0][3] = 8'h77;
    alt_a[1][0] = 4'h8; alt_a[1][1] = 4'h9; alt_a[1][2] = 4'hA; alt_a[1][3] = 4'hB;
    alt_d[1][0] = 8'h88; alt_d[1][1] = 8'h99; alt_d[1][2] = 8'hAA; alt_d[1][3] = 8'hBB;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    spur_vld = 1'b0; spur_data = 8'h00; rf_mute = 1'b0;
    chk_reset = 1'b0; done = 1'b0;
    exp_addr = 4'h0; exp_wd = 8'h00; exp_d0 = 8'h00; exp_d1 = 8'h00; exp_e0 = 1'b0; exp_e1 = 1'b0;

    // Reset state.
    tick(3);
    chk_reset = 1'b1;
    tick(1);
    chk_reset = 1'b0;
    rst = 1'b0;
    tick(1);

    // Single write, then read-after-write from the other requester.
    wr_op(1'b0, 4'h2, 8'hA5);
    rd_op(1'b1, 4'h2, 8'hA5, 1'b0);

    // Spurious Rd_dataValid in IDLE and across a write: no response, normal behaviour after.
    spur_vld = 1'b1; spur_data = 8'hEE;
    tick(2);
    wr_op(1'b1, 4'h6, 8'h3C);
    spur_vld = 1'b0;
    rd_op(1'b0, 4'h6, 8'h3C, 1'b0);

    // Timeout read, then the next request is accepted.
    rd_op(1'b0, 4'h5, 8'h00, 1'b1);
    wr_op(1'b1, 4'h5, 8'h5A);

    // Reset while waiting for read data: transaction abandoned, no response.
    k = cyc;
    exp_addr = 4'h4;
    ev(k + 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rf_mute = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'h4, 8'h00);
    tick(2);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    tick(2);
    rst = 1'b1;
    tick(1);
    exp_addr = 4'h0; exp_wd = 8'h00; exp_d0 = 8'h00; exp_d1 = 8'h00; exp_e0 = 1'b0; exp_e1 = 1'b0;
    chk_reset = 1'b1;
    tick(1);
    chk_reset = 1'b0;
    tick(1);
    rf_mute = 1'b0;

    // Release with both requesters valid: grants alternate 0,1,0,1,... one write every 2 cycles.
    drive(1'b0, 1'b1, 1'b1, alt_a[0][0], alt_d[0][0]);
    drive(1'b1, 1'b1, 1'b1, alt_a[1][0], alt_d[1][0]);
    rst = 1'b0;
    k = cyc;
    for (int i = 0; i < 8; i++) begin
      exp_addr = alt_a[i & 1][i >> 1];
      exp_wd   = alt_d[i & 1][i >> 1];
      ev(k + 1 + 2 * i, 1'b1, 1'b0, (i & 1) == 0, (i & 1) == 1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      tick(2);
      if ((i >> 1) < 3)
        drive(1'(i & 1), 1'b1, 1'b1, alt_a[i & 1][(i >> 1) + 1], alt_d[i & 1][(i >> 1) + 1]);
      else
        drive(1'(i & 1), 1'b0, 1'b0, 4'h0, 8'h00);
    end

    // Read back one of the alternating writes.
    rd_op(1'b1, 4'h9, 8'h99, 1'b0);

    tick(2);
    done = 1'b1;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester round-robin arbiter that shares the single-port register file between the system controller (requester 0) and a secondary master such as a debug/config loader (requester 1). It lives in the reference clock domain, between the requesters and the register file's RdEn/WrEn/address/WrData/RdData/Rd_dataValid port. It serialises accesses, routes read data back to the owning requester and bounds every read with a timeout.

## Interface
- n, 4, address width
- m, 8, data width
- TIMEOUT, 8, max WAIT cycles for Rd_dataValid (≥2)

Ports:
- Clk  in  1  reference clock
- Rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request pending; held with fields until matching ready
- req0_wr / req1_wr  in  1  1=write, 0=read
- req0_addr / req1_addr  in  n  target address
- req0_wdata / req1_wdata  in  m  write data
- req0_ready / req1_ready  out  1  one-cycle pulse: request consumed
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse: read completion
- rsp0_data / rsp1_data  out  m  read data (0 on timeout)
- rsp0_err / rsp1_err  out  1  timeout flag, valid with rspN_valid
- RdEn  out  1  register-file read strobe
- WrEn  out  1  register-file write strobe
- address  out  n  register-file address
- WrData  out  m  register-file write data
- RdData  in  m  register-file read data
- Rd_dataValid  in  1  register-file read data valid
- arb_busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, WR, RD, WAIT. All outputs registered.
- IDLE: valid sampled only here. No valid → stay. Winner chosen → latch winner's wr/addr/wdata, go to WR or RD.
- Arbitration: last_gnt pointer. Single valid → grant it. Both valid → grant the one ≠ last_gnt. last_gnt updated on every grant.
- WR: WrEn=1, address/WrData from latched request, reqN_ready=1 for winner. Next state IDLE.
- RD: RdEn=1, address latched, reqN_ready=1. Next state WAIT, counter cleared.
- WAIT: RdEn=0. Rd_dataValid=1 → capture RdData, next cycle rspN_valid=1, rspN_err=0, go IDLE. Otherwise counter+1. Counter reaches TIMEOUT-1 without valid → next cycle rspN_valid=1, rspN_data=0, rspN_err=1, go IDLE.
- Rd_dataValid outside WAIT is ignored.
- rsp data/err of the non-owning requester stay unchanged. The owning requester's rsp data/err hold until its next completion.
- address/WrData hold their last value when strobes are low.

## Timing
- Reset (Rst=1 at edge): state IDLE, last_gnt=1 so requester 0 wins the first tie, counter 0, all outputs 0 (ready, rsp_valid, rsp_data, rsp_err, RdEn, WrEn, address, WrData, arb_busy).
- Reset mid-read abandons the transaction. No rsp pulse is produced.
- Write, request seen in IDLE at cycle T: WrEn+ready at T+1, IDLE at T+2. Back-to-back writes run at one every 2 cycles.
- Read with a register file of 1-cycle latency: RdEn+ready at T+1, Rd_dataValid at T+2 (WAIT), rsp_valid at T+3 (IDLE). 3-cycle latency, one read every 3 cycles.
- Requester drops valid, or presents its next request, in the cycle after ready. A valid still high when IDLE is re-entered is treated as a new request.
- Timeout: rsp_valid with err arrives TIMEOUT+1 cycles after the RdEn cycle.
- arb_busy is high in WR, RD and WAIT.

## Test plan
- Reset then single write, req0 addr=4'h2 data=8'hA5 → WrEn=1, address=2, WrData=A5 at T+1, req0_ready pulse, no rsp.
- Read-after-write, req1 read addr=2, model returns A5 one cycle after RdEn → rsp1_valid, rsp1_data=A5, rsp1_err=0 at T+3, rsp0 untouched.
- Both valid from reset, each issuing 4 writes → grants alternate 0,1,0,1,…, one WrEn every 2 cycles, 8 writes total.
- Read with Rd_dataValid never asserted, TIMEOUT=8 → rsp_valid=1, data=0, err=1 exactly 9 cycles after RdEn, then IDLE and the next request is accepted.
- Rst asserted during WAIT → no rsp pulse, all outputs 0. After release with both valid, requester 0 is granted first.
- Spurious Rd_dataValid while IDLE or in WR → no rsp pulse, state unaffected.
